ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction-fetch stage sitting directly downstream of the program counter in the Harvard MIPS core.
- Takes the current PC address and issues reads on the instruction-memory port, absorbing memory wait states.
- Drives the PC's halt and immediate controls: stalls the PC while a fetch is outstanding, and applies branch/jump redirects after the MIPS delay slot has been fetched.
- Presents fetched instructions to decode through a one-entry valid/ready output buffer.

Parameters:
- ALIGN_CHECK, 1, when 1 a fetch from pc_addr[1:0] != 0 sets sticky fetch_err.
- NOP_WORD, 32'h00000000, value driven on instr while instr_valid is 0.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pc_addr  in  32  current PC value (PC addr output)
- pc_stall  out  1  to PC halt
- pc_jump  out  1  to PC immediate
- pc_jump_target  out  32  to PC Rd
- imem_address  out  32  instruction memory address
- imem_read  out  1  read request
- imem_waitrequest  in  1  memory not ready; request must be held
- imem_readdata  in  32  instruction word, valid when read && !waitrequest
- instr  out  32  buffered instruction to decode
- instr_addr  out  32  address of instr
- instr_valid  out  1  buffer holds an instruction
- instr_ready  in  1  decode consumes instr this cycle
- redirect  in  1  decode: branch taken; sampled only when instr_valid && instr_ready
- redirect_target  in  32  branch/jump destination
- fetch_err  out  1  sticky misaligned-fetch flag

Behaviour:
- Reset: instr_valid=0, instr=NOP_WORD, instr_addr=0, imem_read=0, pc_jump=0, fetch_err=0, redirect FSM=SEQ.
- pc_stall=1 while reset is high.
- Reset abandons any outstanding read regardless of waitrequest.
- Request rule: imem_read = !reset && (!instr_valid || instr_ready).
- imem_address = pc_addr, combinational.
- accept = imem_read && !imem_waitrequest.
- pc_stall = !accept, so the PC advances by 4 (or jumps) only on the accept edge.
- Buffer update on each edge:
  - accept: instr <= imem_readdata, instr_addr <= pc_addr, instr_valid <= 1.
  - else if instr_ready: instr_valid <= 0 and instr <= NOP_WORD.
- Latency: the word is on instr the cycle after accept. Zero-wait memory with instr_ready=1 sustains 1 instruction/cycle.
- Redirect FSM states: SEQ, SLOT_PENDING. Register tgt_q.
  - The taken event is redirect && instr_valid && instr_ready (the branch is being handed to decode).
  - SEQ, taken, accept in same cycle: the word accepted now is the delay slot. Drive pc_jump=1 and pc_jump_target=redirect_target combinationally. Stay in SEQ.
  - SEQ, taken, no accept: tgt_q <= redirect_target, go to SLOT_PENDING.
  - SLOT_PENDING, accept: pc_jump=1, pc_jump_target=tgt_q, return to SEQ.
  - SLOT_PENDING, no accept: hold.
  - Redirect while in SLOT_PENDING is illegal (a branch cannot sit in a delay slot). Ignore it; the bench asserts it never occurs.
- pc_jump is only ever high in a cycle with accept=1, because the PC gives halt priority over immediate.
- pc_jump_target=0 whenever pc_jump=0.
- Simultaneous accept and instr_ready: the new word replaces the consumed one, and instr_valid stays 1.
- Misalignment: when ALIGN_CHECK=1 and accept with pc_addr[1:0]!=0, fetch_err <= 1 until reset. The fetch still completes normally.
- Wait states: while waitrequest=1, imem_read and imem_address are held stable because the PC is halted. The buffer may still drain.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_VECTOR=32'hBFC00000
  - NOP_WORD default
  - typedef enum logic {SEQ, SLOT_PENDING} redir_state_t
- No sub-module. The single-entry output buffer is inline; total RTL is roughly 150 lines.

Test Plan:
- Reset then zero-wait memory with instr_ready=1 -> first imem_address=32'hBFC00000. instr_valid rises one cycle after reset deasserts, carrying addresses BFC00000, BFC00004, BFC00008 on consecutive cycles; pc_stall=0 throughout.
- waitrequest=1 for 3 cycles on BFC00004 -> pc_stall=1, and imem_address holds BFC00004 for 4 cycles. instr updates once, with instr_addr=BFC00004.
- instr_ready=0 for 2 cycles with a full buffer -> imem_read=0 and pc_stall=1. The PC and instr hold, and fetch resumes the cycle instr_ready returns.
- Taken branch at BFC00008 with target 32'hBFC00100 and a concurrent accept of BFC0000C -> pc_jump=1 with target BFC00100 that cycle. The next fetch address is BFC00100 and the delay slot BFC0000C is delivered.
- Same redirect during a memory wait on BFC0000C -> FSM enters SLOT_PENDING. pc_jump pulses on BFC0000C's accept, with target from tgt_q.
- pc_addr=32'hBFC00002 accepted -> fetch_err=1 and stays 1 until reset. Reset asserted mid-wait -> imem_read=0 and instr_valid=0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the Harvard MIPS core
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR     = 32'hBFC00000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h00000000;

  // SLOT_PENDING: a taken branch has gone to decode but its delay slot
  // has not been accepted from memory yet.
  typedef enum logic {
    SEQ          = 1'b0,
    SLOT_PENDING = 1'b1
  } redir_state_t;

endpackage

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage with one-entry output buffer and delay-slot redirect
module ifetch_unit
  import mips_pkg::*;
#(
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  output logic        pc_stall,
  output logic        pc_jump,
  output logic [31:0] pc_jump_target,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic        imem_waitrequest,
  input  logic [31:0] imem_readdata,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fetch_err
);

  redir_state_t state_q, state_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  instr_q, instr_addr_q;
  logic         instr_valid_q;
  logic         fetch_err_q;
  logic         accept;
  logic         taken;

  // A read is only issued when the buffer has room (empty or draining this cycle).
  // The PC is halted until the word is accepted, so the address stays stable across wait states.
  assign imem_read    = !reset && (!instr_valid_q || instr_ready);
  assign imem_address = pc_addr;
  assign accept       = imem_read && !imem_waitrequest;
  assign pc_stall     = !accept;

  // The branch is handed to decode this cycle; the next fetched word is its delay slot.
  assign taken = redirect && instr_valid_q && instr_ready;

  assign instr       = instr_q;
  assign instr_addr  = instr_addr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

  // Redirect next-state and PC jump control; jump only ever coincides with an accept.
  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    pc_jump        = 1'b0;
    pc_jump_target = 32'h0;
    case (state_q)
      SEQ: begin
        if (taken) begin
          if (accept) begin
            pc_jump        = 1'b1;
            pc_jump_target = redirect_target;
          end else begin
            tgt_d   = redirect_target;
            state_d = SLOT_PENDING;
          end
        end
      end
      SLOT_PENDING: begin
        if (accept) begin
          pc_jump        = 1'b1;
          pc_jump_target = tgt_q;
          state_d        = SEQ;
        end
      end
      default: state_d = SEQ;
    endcase
  end

  // Redirect state and saved target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // Output buffer: an accepted word replaces whatever decode consumed this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q       <= NOP_WORD;
      instr_addr_q  <= 32'h0;
      instr_valid_q <= 1'b0;
    end else if (accept) begin
      instr_q       <= imem_readdata;
      instr_addr_q  <= pc_addr;
      instr_valid_q <= 1'b1;
    end else if (instr_ready) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
    end
  end

  // Sticky misaligned-fetch flag; the fetch itself still completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_err_q <= 1'b0;
    end else if (ALIGN_CHECK && accept && (pc_addr[1:0] != 2'b00)) begin
      fetch_err_q <= 1'b1;
    end
  end

endmodule
